// File: rtl/nibble_cmp_seq_if.sv
// Operand, comparator and result bundle for nibble_cmp_seq.
// slave is the sequencer side; master is the producer/consumer/comparator side.
interface nibble_cmp_seq_if #(
   parameter int WIDTH = 16
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = $clog2(NIB) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [3:0]       cmp_a;
   logic [3:0]       cmp_b;
   logic             cmp_gt;
   logic             cmp_eq;
   logic             cmp_lt;
   logic             out_valid;
   logic             out_ready;
   logic             out_gt;
   logic             out_eq;
   logic             out_lt;
   logic             out_err;
   logic [CW-1:0]    out_cycles;

   modport slave (
      input  in_valid, in_a, in_b, cmp_gt, cmp_eq, cmp_lt, out_ready,
      output in_ready, cmp_a, cmp_b, out_valid, out_gt, out_eq, out_lt,
             out_err, out_cycles
   );

   modport master (
      output in_valid, in_a, in_b, cmp_gt, cmp_eq, cmp_lt, out_ready,
      input  in_ready, cmp_a, cmp_b, out_valid, out_gt, out_eq, out_lt,
             out_err, out_cycles
   );
endinterface

// File: rtl/nibble_cmp_seq.sv
// Walks two WIDTH-bit operands MSB nibble first through an external 4-bit comparator.
// Result valid k cycles after accept (k = leading equal nibbles + 1, max NIB); result held until out_ready.
module nibble_cmp_seq #(
   parameter int WIDTH = 16
) (
   input logic              clk,
   input logic              rst_n,
   nibble_cmp_seq_if.slave  bus
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = $clog2(NIB) + 1;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    count;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic             res_gt;
   logic             res_eq;
   logic             res_lt;
   logic             res_err;

   logic [IW-1:0]    idx_nxt;
   logic [3:0]       nib_a_nxt;
   logic [3:0]       nib_b_nxt;
   logic             flags_onehot;

   always_comb begin
      idx_nxt      = idx - IW'(1);
      nib_a_nxt    = a_reg[{idx_nxt, 2'b00} +: 4];
      nib_b_nxt    = b_reg[{idx_nxt, 2'b00} +: 4];
      flags_onehot = (bus.cmp_gt ^ bus.cmp_eq ^ bus.cmp_lt) &
                     ~(bus.cmp_gt & bus.cmp_eq & bus.cmp_lt);
   end

   // Comparator nibbles are registered one step ahead so cmp_a/cmp_b come
   // straight from flops rather than through the idx-driven mux.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         idx     <= '0;
         count   <= '0;
         nib_a   <= '0;
         nib_b   <= '0;
         res_gt  <= 1'b0;
         res_eq  <= 1'b0;
         res_lt  <= 1'b0;
         res_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg <= bus.in_a;
                  b_reg <= bus.in_b;
                  idx   <= IW'(NIB - 1);
                  count <= '0;
                  nib_a <= bus.in_a[WIDTH-1 -: 4];
                  nib_b <= bus.in_b[WIDTH-1 -: 4];
                  state <= RUN;
               end
            end
            RUN: begin
               count <= count + CW'(1);
               nib_a <= '0;
               nib_b <= '0;
               if (!flags_onehot) begin
                  res_err <= 1'b1;
                  state   <= DONE;
               end else if (bus.cmp_gt) begin
                  res_gt <= 1'b1;
                  state  <= DONE;
               end else if (bus.cmp_lt) begin
                  res_lt <= 1'b1;
                  state  <= DONE;
               end else if (idx == '0) begin
                  res_eq <= 1'b1;
                  state  <= DONE;
               end else begin
                  idx   <= idx_nxt;
                  nib_a <= nib_a_nxt;
                  nib_b <= nib_b_nxt;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  res_gt  <= 1'b0;
                  res_eq  <= 1'b0;
                  res_lt  <= 1'b0;
                  res_err <= 1'b0;
                  count   <= '0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = (state == DONE);
   assign bus.cmp_a      = nib_a;
   assign bus.cmp_b      = nib_b;
   assign bus.out_gt     = res_gt;
   assign bus.out_eq     = res_eq;
   assign bus.out_lt     = res_lt;
   assign bus.out_err    = res_err;
   assign bus.out_cycles = count;
endmodule

// File: tb/tb_nibble_cmp_seq.sv
// Bench for nibble_cmp_seq (WIDTH=16) with a behavioural 4-bit comparator
// and a whole-operand reference model.
module tb_nibble_cmp_seq;
   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic clk;
   logic rst_n;
   logic force_fault;
   int   errors;
   int   checks;
   logic [3:0] seq_a[$];
   logic [3:0] seq_b[$];

   nibble_cmp_seq_if #(.WIDTH(WIDTH)) bus ();

   nibble_cmp_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // The team comparator, with an override that makes gt and lt fire together.
   assign bus.cmp_gt = force_fault | (bus.cmp_a > bus.cmp_b);
   assign bus.cmp_lt = force_fault | (bus.cmp_a < bus.cmp_b);
   assign bus.cmp_eq = ~force_fault & (bus.cmp_a == bus.cmp_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] flags();
      return {bus.out_gt, bus.out_eq, bus.out_lt, bus.out_err};
   endfunction

   // Nibbles examined = position of the most significant differing nibble.
   function automatic int model_k(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] d;
      d = a ^ b;
      for (int i = NIB - 1; i >= 0; i--)
         if (((d >> (4 * i)) & 16'hF) != 0) return NIB - i;
      return NIB;
   endfunction

   function automatic logic [3:0] nib_of(input logic [15:0] v, input int j);
      return 4'((v >> (4 * (NIB - 1 - j))) & 16'hF);
   endfunction

   task automatic drive_op(input logic [15:0] a, input logic [15:0] b, output int lat);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_a     = 16'($urandom);
      bus.in_b     = 16'($urandom);
      seq_a.delete();
      seq_b.delete();
      n = 0;
      while (!bus.out_valid && n < 20) begin
         seq_a.push_back(bus.cmp_a);
         seq_b.push_back(bus.cmp_b);
         @(posedge clk); #1; n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL op_timeout a=%h b=%h: out_valid=%b after %0d cycles, required 1", a, b, bus.out_valid, n);
      end
      lat = n;
   endtask

   task automatic finish_op();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || flags() !== 4'b0000 ||
          bus.out_cycles !== 3'd0 || bus.cmp_a !== 4'd0 || bus.cmp_b !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b flags=%b cycles=%0d cmp=%h/%h, required 1 0 0000 0 0/0",
                  bus.in_ready, bus.out_valid, flags(), bus.out_cycles, bus.cmp_a, bus.cmp_b);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_equal();
      int lat;
      bit bad;
      drive_op(16'h1234, 16'h1234, lat);
      checks++;
      if (flags() !== 4'b0100) begin
         errors++; $display("FAIL equal_flags: got %b, required 0100", flags());
      end
      checks++;
      if (bus.out_cycles !== 3'd4 || lat != 4) begin
         errors++; $display("FAIL equal_cycles: cycles=%0d latency=%0d, required 4 4", bus.out_cycles, lat);
      end
      bad = (seq_a.size() != 4);
      for (int j = 0; j < seq_a.size() && j < 4; j++)
         if (seq_a[j] !== 4'(j + 1) || seq_b[j] !== 4'(j + 1)) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++; $display("FAIL equal_nibble_seq: got %p, required 1,2,3,4", seq_a);
      end
      finish_op();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || flags() !== 4'b0000) begin
         errors++;
         $display("FAIL equal_handshake: in_ready=%b out_valid=%b flags=%b, required 1 0 0000",
                  bus.in_ready, bus.out_valid, flags());
      end
   endtask

   task automatic test_msb_diff();
      int lat;
      drive_op(16'h8000, 16'h7FFF, lat);
      checks++;
      if (flags() !== 4'b1000 || bus.out_cycles !== 3'd1 || lat != 1) begin
         errors++;
         $display("FAIL msb_diff: flags=%b cycles=%0d latency=%0d, required 1000 1 1", flags(), bus.out_cycles, lat);
      end
      finish_op();
   endtask

   task automatic test_mid_diff();
      int lat;
      drive_op(16'h12A4, 16'h12B4, lat);
      checks++;
      if (flags() !== 4'b0010 || bus.out_cycles !== 3'd3 || lat != 3) begin
         errors++;
         $display("FAIL mid_diff: flags=%b cycles=%0d latency=%0d, required 0010 3 3", flags(), bus.out_cycles, lat);
      end
      checks++;
      if (seq_a.size() != 3 || seq_a[2] !== 4'hA || seq_b[2] !== 4'hB) begin
         errors++; $display("FAIL mid_nibble_seq: a=%p b=%p, required 1,2,a / 1,2,b", seq_a, seq_b);
      end
      finish_op();
   endtask

   task automatic test_back_pressure();
      int lat;
      drive_op(16'hFFFF, 16'h0000, lat);
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h0001;
      bus.in_b     = 16'h0002;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || flags() !== 4'b1000 || bus.out_cycles !== 3'd1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: out_valid=%b flags=%b cycles=%0d in_ready=%b, required 1 1000 1 0",
                     c, bus.out_valid, flags(), bus.out_cycles, bus.in_ready);
         end
      end
      finish_op();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
      end
      drive_op(16'h0001, 16'h0002, lat);
      checks++;
      if (flags() !== 4'b0010 || bus.out_cycles !== 3'd4) begin
         errors++;
         $display("FAIL bp_second_op: flags=%b cycles=%0d, required 0010 4", flags(), bus.out_cycles);
      end
      finish_op();
   endtask

   task automatic test_reset_run();
      int lat;
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h1111;
      bus.in_b     = 16'h1112;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || flags() !== 4'b0000 ||
          bus.out_cycles !== 3'd0 || bus.cmp_a !== 4'd0 || bus.cmp_b !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid_run: in_ready=%b out_valid=%b flags=%b cycles=%0d cmp=%h/%h, required 1 0 0000 0 0/0",
                  bus.in_ready, bus.out_valid, flags(), bus.out_cycles, bus.cmp_a, bus.cmp_b);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_discard: out_valid=%b, required 0", bus.out_valid);
      end
      drive_op(16'h0005, 16'h0003, lat);
      checks++;
      if (flags() !== 4'b1000 || bus.out_cycles !== 3'd4 || lat != 4) begin
         errors++;
         $display("FAIL reset_recover: flags=%b cycles=%0d latency=%0d, required 1000 4 4", flags(), bus.out_cycles, lat);
      end
      finish_op();
   endtask

   task automatic test_flag_fault();
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h1234;
      bus.in_b     = 16'h1234;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      force_fault  = 1'b1;
      @(posedge clk); #1;
      force_fault  = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || flags() !== 4'b0001 || bus.out_cycles !== 3'd1) begin
         errors++;
         $display("FAIL flag_fault: out_valid=%b flags=%b cycles=%0d, required 1 0001 1",
                  bus.out_valid, flags(), bus.out_cycles);
      end
      finish_op();
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      logic [3:0]  exp_flags, held;
      int          k, lat, hold;
      bit          bad;
      for (int it = 0; it < 60; it++) begin
         a = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       b = a;
            1:       b = 16'($urandom);
            default: b = a ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIB - 1)));
         endcase
         exp_flags = {a > b, a == b, a < b, 1'b0};
         k = model_k(a, b);
         drive_op(a, b, lat);
         checks++;
         if (flags() !== exp_flags || bus.out_cycles !== 3'(k) || lat != k) begin
            errors++;
            $display("FAIL rand[%0d] a=%h b=%h: flags=%b cycles=%0d latency=%0d, required %b %0d %0d",
                     it, a, b, flags(), bus.out_cycles, lat, exp_flags, k, k);
         end
         bad = (seq_a.size() != k);
         for (int j = 0; j < seq_a.size() && j < k; j++)
            if (seq_a[j] !== nib_of(a, j) || seq_b[j] !== nib_of(b, j)) bad = 1'b1;
         checks++;
         if (bad) begin
            errors++; $display("FAIL rand_seq[%0d] a=%h b=%h: got %p / %p", it, a, b, seq_a, seq_b);
         end
         hold = $urandom_range(0, 3);
         held = flags();
         for (int c = 0; c < hold; c++) begin
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || flags() !== held || bus.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL rand_hold[%0d]: out_valid=%b flags=%b in_ready=%b, required 1 %b 0",
                        it, bus.out_valid, flags(), bus.in_ready, held);
            end
         end
         bus.in_valid = 1'b0;
         finish_op();
      end
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      force_fault    = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_a       = '0;
      bus.in_b       = '0;
      bus.out_ready  = 1'b0;
      test_reset();
      test_equal();
      test_msb_diff();
      test_mid_diff();
      test_back_pressure();
      test_reset_run();
      test_flag_fault();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
